// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants and digit legality helper
// Purpose: common definitions for the BCD counter and its decade cells.
// Contents: BCD_W (digit width), BCD_MAX/BCD_MIN (digit range), is_bcd().
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // 1 when the 4-bit code is a legal decimal digit (0-9)
  function automatic logic is_bcd(input logic [3:0] v);
    return (v <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decade cell of the BCD up/down counter
// Purpose: holds one BCD digit, steps it up or down, and passes a
//          carry/borrow to the next cell.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   load       in   parallel load strobe
//   load_digit in   4-bit load value (codes >9 are stored as 0)
//   step_in    in   step request from the previous cell (or enable)
//   up         in   direction, 1 = increment
//   digit      out  current digit, always 0-9
//   step_out   out  carry (up) or borrow (down) into the next cell
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step_in,
  input  logic       up,
  output logic [3:0] digit,
  output logic       step_out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= is_bcd(load_digit) ? load_digit : BCD_MIN;
    end else if (step_in) begin
      if (up) begin
        digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
      end else begin
        digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
      end
    end
  end

  // Combinational so a carry ripples through every cell in one cycle
  assign step_out = step_in & (up ? (digit == BCD_MAX) : (digit == BCD_MIN));

endmodule

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - multi-digit BCD up/down counter with parallel load
// Purpose: cascades NUM_DIGITS decade cells; flags wrap-around and
//          illegal load digits with one-cycle registered pulses.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   en        in   count enable
//   up        in   direction, 1 = increment
//   load      in   parallel load strobe (wins over en)
//   load_val  in   packed BCD load value, digit 0 in [3:0]
//   count     out  packed BCD count, digit 0 in [3:0]
//   wrap      out  pulse in the cycle the count shows the wrapped value
//   load_err  out  pulse in the cycle after a load with a digit >9
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        up,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
  output logic [BCD_W*NUM_DIGITS-1:0] count,
  output logic                        wrap,
  output logic                        load_err
);

  logic [NUM_DIGITS:0]   step;
  logic [NUM_DIGITS-1:0] invalid;

  // Load masks the step chain, so a load cycle can never report a wrap
  assign step[0] = en & ~load;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_digit (load_val[BCD_W*i +: BCD_W]),
      .step_in    (step[i]),
      .up         (up),
      .digit      (count[BCD_W*i +: BCD_W]),
      .step_out   (step[i+1])
    );
    assign invalid[i] = ~is_bcd(load_val[BCD_W*i +: BCD_W]);
  end

  // A step leaving the top cell means every digit rolled over
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= step[NUM_DIGITS];
      load_err <= load & (|invalid);
    end
  end

endmodule

// File: doc/bcd_counter.md
Name: bcd_counter

Overview:
- Synchronous multi-digit BCD up/down counter with parallel load.
- Produces the packed BCD digit bus consumed by the per-digit BCD-to-decimal one-hot decoder stage.
- Decoder mapping for each digit: bit0→A1, bit1→A2, bit2→A4, bit3→A8.
- Every digit output is always a legal BCD value (0–9), so the downstream decoder never sees codes 10–15.

Parameters:
- NUM_DIGITS, 2, number of cascaded decimal digits; legal range 1–4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction; 1 = increment, 0 = decrement; sampled only when stepping.
- load  input  1  parallel load strobe.
- load_val  input  4*NUM_DIGITS  packed BCD load value; digit 0 (least significant) in [3:0].
- count  output  4*NUM_DIGITS  packed BCD count; digit 0 in [3:0].
- wrap  output  1  one-cycle pulse when the count wraps (all-9s→0 going up, 0→all-9s going down).
- load_err  output  1  one-cycle pulse when a load contained at least one digit >9.

Behaviour:
- Reset (rst=1 at an edge): count=0, wrap=0, load_err=0. Reset overrides load and en in the same cycle.
- Priority per edge: rst > load > en > hold.
- Load:
  - count takes load_val on the next edge (latency 1).
  - Any digit >9 (codes 10–15) is stored as 0; other digits are stored as given.
  - load_err=1 for exactly that cycle if any digit was replaced, otherwise 0.
  - wrap=0 on a load cycle.
  - en is ignored in a load cycle.
- Count up (en=1, up=1, no load):
  - Digit 0 increments.
  - A digit at 9 becomes 0 and generates an internal carry into the next digit; other digits are unchanged.
  - Carry ripples combinationally through all digits within the same cycle.
- Count down (en=1, up=0, no load):
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and generates an internal borrow into the next digit.
- Wrap:
  - Up from all-9s gives all-0s; down from all-0s gives all-9s.
  - wrap is registered: high for the single cycle whose count shows the wrapped value, low in all other cycles.
  - Continuous counting across repeated wraps produces one pulse per wrap.
- Hold: with en=0 and load=0, count is unchanged and wrap=0, load_err=0.
- Direction change: up may change every cycle; each step uses the up value sampled at that edge. No hysteresis or extra latency.
- Reset mid-count: the count returns to 0 on that edge. A wrap or load_err pulse pending for that edge is suppressed (forced 0).
- No internal state other than the digit registers and the two pulse flops.
- Counting must never produce codes 10–15 on any digit.

Decomposition:
- Shared package bcd_pkg:
  - BCD_MAX=4'd9, BCD_MIN=4'd0, BCD_W=4.
  - Function is_bcd(4-bit) returning 1 when the value is ≤9.
- Sub-module bcd_digit: one 4-bit decade cell.
  - Inputs: clk, rst, load, load_digit, step_in, up.
  - Outputs: digit, step_out, where step_out = step_in & (up ? digit==9 : digit==0).
  - Load sanitising (>9→0) is done inside the cell.
- Top level:
  - Generates NUM_DIGITS cells chained via step_out→step_in; cell 0 takes step_in=en & ~load.
  - wrap register is set from the last cell's step_out.
  - load_err register is set from the OR of per-digit invalid flags when load=1.

Test Plan:
- Reset, then en=1, up=1 for 100 cycles (NUM_DIGITS=2) → count runs 00,01…09,10…99,00. wrap high only in the cycle count=00 after 99. Each digit stays ≤9 throughout.
- load=1, load_val=8'h00, then en=1, up=0 for 3 cycles → 99 (wrap=1), 98 (wrap=0), 97.
- load=1 with load_val=8'h5C → count=8'h50 next cycle, load_err=1 for one cycle. Then load_val=8'h37 → count=8'h37, load_err=0.
- From count=8'h19: en=1, up=1 gives 20. Toggle up=0 next cycle → 19. Assert load=1 with en=1 and load_val=8'h42 → 42 (load wins), wrap=0.
- From count=8'h99 with en=1, up=1, assert rst on the same edge → count=00, wrap=0. Then en=0 for 5 cycles → count holds 00, no pulses.
- NUM_DIGITS=1: counting up from 9 → 0 with wrap=1; load 4'hF → 0 with load_err=1.
